// File: rtl/pll_dyn_cfg_ctrl_pkg.sv
// pll_dyn_cfg_ctrl_pkg: sequencer states, divider-code widths and power-up divider codes
package pll_dyn_cfg_ctrl_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_ASSERT, ST_WAITL, ST_STABLE, ST_FAIL} state_t;
  localparam int ID_W = 6;
  localparam int FB_W = 6;
  localparam int MD_W = 7;
  localparam int OD_W = 7;
  localparam logic [ID_W-1:0] INIT_IDSEL_DEF = 6'd3;
  localparam logic [FB_W-1:0] INIT_FBDSEL_DEF = 6'd9;
  localparam logic [MD_W-1:0] INIT_MDSEL_DEF = 7'd12;
  localparam logic [OD_W-1:0] INIT_ODSEL0_DEF = 7'd8;
  localparam logic [OD_W-1:0] INIT_ODSEL1_DEF = 7'd16;
  localparam logic [OD_W-1:0] INIT_ODSEL2_DEF = 7'd32;
  localparam logic [OD_W-1:0] INIT_ODSEL3_DEF = 7'd64;
endpackage

// File: rtl/pll_dyn_cfg_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops, both clearing on reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: PLL reset/lock sequencer applying power-up and requested divider codes
module pll_dyn_cfg_ctrl
  import pll_dyn_cfg_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY = 3,
  parameter logic [ID_W-1:0] INIT_IDSEL = INIT_IDSEL_DEF,
  parameter logic [FB_W-1:0] INIT_FBDSEL = INIT_FBDSEL_DEF,
  parameter logic [MD_W-1:0] INIT_MDSEL = INIT_MDSEL_DEF,
  parameter logic [OD_W-1:0] INIT_ODSEL0 = INIT_ODSEL0_DEF,
  parameter logic [OD_W-1:0] INIT_ODSEL1 = INIT_ODSEL1_DEF,
  parameter logic [OD_W-1:0] INIT_ODSEL2 = INIT_ODSEL2_DEF,
  parameter logic [OD_W-1:0] INIT_ODSEL3 = INIT_ODSEL3_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_req,
  input  logic [ID_W-1:0]   cfg_idsel,
  input  logic [FB_W-1:0]   cfg_fbdsel,
  input  logic [MD_W-1:0]   cfg_mdsel,
  input  logic [4*OD_W-1:0] cfg_odsel,
  output logic              cfg_ack,
  output logic              cfg_err,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [ID_W-1:0]   pll_idsel,
  output logic [FB_W-1:0]   pll_fbdsel,
  output logic [MD_W-1:0]   pll_mdsel,
  output logic [4*OD_W-1:0] pll_odsel,
  output logic [3:0]        pll_enclk,
  output logic              pll_ready,
  output logic              busy
);
  localparam int PH_N = RST_CYCLES > STABLE_CYCLES ? RST_CYCLES : STABLE_CYCLES;
  localparam int PW = $clog2(PH_N + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [PW-1:0] RST_LAST = PW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] STB_LAST = PW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RT_LAST = RW'(MAX_RETRY - 1);
  localparam logic [4*OD_W-1:0] INIT_ODSEL = {INIT_ODSEL3, INIT_ODSEL2, INIT_ODSEL1, INIT_ODSEL0};
  state_t state;
  logic lock_s, req_mode, accept, restart;
  logic [PW-1:0] phase;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] retry;
  sync_2ff u_sync (.clk(clk), .resetn(resetn), .d(pll_lock), .q(lock_s));
  assign accept = cfg_req && !cfg_ack && (state == ST_IDLE || state == ST_FAIL);
  assign restart = accept || (state == ST_IDLE && !lock_s);
  // sequencer: reset pulse, lock wait with retries, stability qualification and handshake
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= ST_ASSERT;
      phase <= '0;
      tcnt <= '0;
      retry <= '0;
      req_mode <= 1'b0;
      pll_reset <= 1'b1;
      pll_enclk <= '0;
      pll_ready <= 1'b0;
      busy <= 1'b1;
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      pll_idsel <= INIT_IDSEL;
      pll_fbdsel <= INIT_FBDSEL;
      pll_mdsel <= INIT_MDSEL;
      pll_odsel <= INIT_ODSEL;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      if (restart) begin
        state <= ST_ASSERT;
        phase <= '0;
        retry <= '0;
        req_mode <= accept;
        pll_reset <= 1'b1;
        pll_enclk <= '0;
        pll_ready <= 1'b0;
        busy <= 1'b1;
        if (accept) begin
          pll_idsel <= cfg_idsel;
          pll_fbdsel <= cfg_fbdsel;
          pll_mdsel <= cfg_mdsel;
          pll_odsel <= cfg_odsel;
        end
      end else
        case (state)
          ST_ASSERT:
            if (phase >= RST_LAST) begin
              state <= ST_WAITL;
              pll_reset <= 1'b0;
              tcnt <= '0;
            end else phase <= phase + 1'b1;
          ST_WAITL:
            if (lock_s) begin
              state <= ST_STABLE;
              phase <= PW'(1);
            end else if (tcnt >= TO_LAST) begin
              phase <= '0;
              pll_reset <= 1'b1;
              if (retry >= RT_LAST) begin
                state <= ST_FAIL;
                busy <= 1'b0;
                cfg_ack <= req_mode;
                cfg_err <= req_mode;
              end else begin
                state <= ST_ASSERT;
                retry <= retry + 1'b1;
              end
            end else tcnt <= tcnt + 1'b1;
          ST_STABLE:
            if (!lock_s) state <= ST_WAITL;
            else if (phase >= STB_LAST) begin
              state <= ST_IDLE;
              pll_ready <= 1'b1;
              pll_enclk <= '1;
              busy <= 1'b0;
              cfg_ack <= req_mode;
            end else phase <= phase + 1'b1;
          default: ;
        endcase
    end
endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// tb_pll_dyn_cfg_ctrl: randomized event-timing checks of the PLL sequencer against a PLL model
module tb_pll_dyn_cfg_ctrl;
  import pll_dyn_cfg_ctrl_pkg::*;
  localparam int RST_CYCLES = 16;
  localparam int LOCK_TIMEOUT = 600;
  localparam int STABLE_CYCLES = 256;
  localparam int MAX_RETRY = 3;
  localparam logic [27:0] INIT_OD = {INIT_ODSEL3_DEF, INIT_ODSEL2_DEF, INIT_ODSEL1_DEF, INIT_ODSEL0_DEF};
  localparam logic [46:0] INIT_CODES = {INIT_IDSEL_DEF, INIT_FBDSEL_DEF, INIT_MDSEL_DEF, INIT_OD};
  logic clk = 1'b0, resetn = 1'b0, cfg_req = 1'b0, pll_lock = 1'b0;
  logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0;
  logic [6:0] cfg_mdsel = '0;
  logic [27:0] cfg_odsel = '0;
  logic cfg_ack, cfg_err, pll_reset, pll_ready, busy;
  logic [5:0] pll_idsel, pll_fbdsel;
  logic [6:0] pll_mdsel;
  logic [27:0] pll_odsel;
  logic [3:0] pll_enclk;
  int checks = 0, errors = 0;
  int cyc = 0, since = 0, lock_delay = 40, glitch_off = 0, lock_rise = -1, lock_fall = -1;
  bit force_low = 0;
  logic nl;
  int ready_rise = -1, ready_fall = -1, rst_rise = -1, ack_cnt = 0, ack_cyc = -1;
  logic ack_err = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1;
  int rst_falls[$];
  logic [46:0] exp_codes;

  pll_dyn_cfg_ctrl #(.RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .resetn(resetn), .cfg_req(cfg_req), .cfg_idsel(cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel), .cfg_mdsel(cfg_mdsel), .cfg_odsel(cfg_odsel),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_mdsel(pll_mdsel),
    .pll_odsel(pll_odsel), .pll_enclk(pll_enclk), .pll_ready(pll_ready), .busy(busy));

  always #5 clk = ~clk;

  // PLL model: lock rises lock_delay cycles after reset release, with optional glitch/forced loss
  always @(posedge clk) begin
    cyc++;
    #2;
    since = pll_reset ? 0 : since + 1;
    nl = !pll_reset && lock_delay >= 0 && since >= lock_delay && !force_low &&
         !(glitch_off > 0 && since == lock_delay + glitch_off);
    if (nl && !pll_lock) lock_rise = cyc;
    if (!nl && pll_lock) lock_fall = cyc;
    pll_lock = nl;
  end

  // event recorder: edge index at which each output changed
  always @(negedge clk) begin
    if (pll_ready && !prev_ready) ready_rise = cyc;
    if (!pll_ready && prev_ready) ready_fall = cyc;
    if (pll_reset && !prev_reset) rst_rise = cyc;
    if (!pll_reset && prev_reset) rst_falls.push_back(cyc);
    if (cfg_ack) begin ack_cnt++; ack_cyc = cyc; ack_err = cfg_err; end
    prev_ready = pll_ready;
    prev_reset = pll_reset;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_on(input string tag, input bit ack, input int budget);
    int n = 0;
    while (!(ack ? cfg_ack : pll_ready) && n < budget) begin tick(1); n++; end
    check(tag, ack ? cfg_ack : pll_ready, 1);
  endtask

  task automatic request(input logic [5:0] id, input logic [5:0] fb, input logic [6:0] md, input logic [27:0] od);
    cfg_idsel = id; cfg_fbdsel = fb; cfg_mdsel = md; cfg_odsel = od;
    exp_codes = {id, fb, md, od};
    cfg_req = 1'b1;
    tick(1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst"}, pll_reset, 1);
    check({tag, "_enclk"}, pll_enclk, 0);
    check({tag, "_ready"}, pll_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ack"}, {cfg_ack, cfg_err}, 0);
    check({tag, "_codes"}, {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, INIT_CODES);
  endtask

  task automatic power_up(input string tag);
    int rel, acks;
    lock_delay = $urandom_range(20, 60);
    rst_falls.delete();
    acks = ack_cnt;
    rel = cyc;
    resetn = 1'b1;
    wait_on({tag, "_ready"}, 0, 1000);
    check({tag, "_rst_len"}, rst_falls.size() > 0 ? rst_falls[0] - rel : -1, RST_CYCLES);
    check({tag, "_ready_t"}, ready_rise - lock_rise, 2 + STABLE_CYCLES);
    check({tag, "_noack"}, ack_cnt, acks);
    check({tag, "_on"}, {pll_enclk, busy}, 5'b11110);
    check({tag, "_codes"}, {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, INIT_CODES);
  endtask

  initial begin
    int l, g, a0;
    logic [6:0] o1, o2, o3;
    tick(3);
    check_reset_vals("reset");
    power_up("pu");

    o1 = 7'($urandom); o2 = 7'($urandom); o3 = 7'($urandom);
    request(6'($urandom), 6'($urandom), 7'd20, {o3, o2, o1, 7'd50});
    check("t2_enclk", pll_enclk, 0);
    check("t2_rst", pll_reset, 1);
    check("t2_md", pll_mdsel, 20);
    check("t2_od", pll_odsel, {o3, o2, o1, 7'd50});
    cfg_idsel = 6'($urandom); cfg_mdsel = 7'($urandom); cfg_odsel = 28'($urandom);
    tick(5);
    check("t2_md_hold", {pll_reset, pll_mdsel}, {1'b1, 7'd20});
    wait_on("t2_ack", 1, 1000);
    cfg_req = 1'b0;
    check("t2_err", cfg_err, 0);
    check("t2_ack_t", ack_cyc, ready_rise);
    check("t2_ready_t", ready_rise - lock_rise, 2 + STABLE_CYCLES);
    check("t2_codes", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, exp_codes);
    tick(1);
    check("t2_pulse", cfg_ack, 0);

    g = $urandom_range(90, 110);
    glitch_off = g;
    request(6'($urandom), 6'($urandom), 7'($urandom), 28'($urandom));
    a0 = 0;
    while (!pll_lock && a0 < 200) begin tick(1); a0++; end
    l = lock_rise;
    wait_on("t4_ack", 1, 1500);
    cfg_req = 1'b0;
    check("t4_err", cfg_err, 0);
    check("t4_relock", lock_rise, l + g + 1);
    check("t4_ready_t", ready_rise, l + g + 1 + 2 + STABLE_CYCLES);
    glitch_off = 0;

    tick(3);
    a0 = ack_cnt;
    ready_fall = -1;
    force_low = 1;
    tick(6);
    check("t5_drop", (ready_fall - lock_fall) inside {[1:3]}, 1);
    check("t5_reseq", {pll_reset, pll_enclk, busy}, 6'b100001);
    check("t5_codes", {pll_idsel, pll_fbdsel, pll_mdsel, pll_odsel}, exp_codes);
    force_low = 0;
    wait_on("t5_ready", 0, 1000);
    check("t5_ready_t", ready_rise - lock_rise, 2 + STABLE_CYCLES);
    tick(3);
    check("t5_noack", ack_cnt, a0);

    lock_delay = -1;
    rst_falls.delete();
    request(6'($urandom), 6'($urandom), 7'($urandom), 28'($urandom));
    wait_on("t3_ack", 1, MAX_RETRY * (RST_CYCLES + LOCK_TIMEOUT) + 200);
    cfg_req = 1'b0;
    check("t3_err", ack_err, 1);
    check("t3_pulses", rst_falls.size(), MAX_RETRY);
    for (int i = 0; i + 1 < rst_falls.size(); i++)
      check("t3_space", rst_falls[i+1] - rst_falls[i], RST_CYCLES + LOCK_TIMEOUT);
    check("t3_fail_t", rst_falls.size() > 0 ? ack_cyc - rst_falls[rst_falls.size()-1] : -1, LOCK_TIMEOUT);
    tick(20);
    check("t3_hold", {pll_reset, pll_enclk, pll_ready}, 6'b100000);

    lock_delay = 150;
    rst_falls.delete();
    request(~INIT_IDSEL_DEF, ~INIT_FBDSEL_DEF, ~INIT_MDSEL_DEF, ~INIT_OD);
    cfg_req = 1'b0;
    check("t6_restart", {pll_reset, busy}, 2'b11);
    a0 = 0;
    while (rst_falls.size() == 0 && a0 < 100) begin tick(1); a0++; end
    tick(10);
    check("t6_waitl", {pll_reset, pll_idsel}, {1'b0, ~INIT_IDSEL_DEF});
    #2 resetn = 1'b0;
    #1 check_reset_vals("t6");
    tick(2);
    power_up("t6_pu");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1);
  end
endmodule
